// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Build option: define UART_TX_PARITY_EN to include the PARITY state and parity logic.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned PW = 6;
    localparam int unsigned IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                state_q;
    logic [PW-1:0]         cnt_q;
    logic [PW-1:0]         pre_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    // Last cycle of the current bit, measured against the latched prescale
    assign bit_end = (cnt_q == (pre_q - PW'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= PW'(1);
            idx_q     <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        pre_q     <= (Prescale == '0) ? PW'(1) : Prescale;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
`endif
                        state_q   <= START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= data_q[0];
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_q <= PARITY;
                                tx_q    <= (^data_q) ^ par_typ_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                            tx_q  <= data_q[idx_q + IW'(1)];
                        end
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_tests;
    int n_fail;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the sample point right after the accepting edge; walks the whole frame
    task automatic capture(input string tag, input logic [7:0] d, input logic pe,
                           input logic pt, input int p);
        int   nbits;
        int   cyc;
        int   k;
        int   pos;
        logic use_par;
        logic exp_bit;
`ifdef UART_TX_PARITY_EN
        use_par = pe;
`else
        use_par = 1'b0 & pe;
`endif
        nbits = use_par ? 11 : 10;
        check({tag, "_busy_rise"}, 32'(Busy), 32'd1);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 800) begin
            k   = cyc / p;
            pos = cyc % p;
            if ((pos == 0 || pos == p - 1) && k < nbits) begin
                if (k == 0)                  exp_bit = 1'b0;
                else if (k <= 8)             exp_bit = d[k-1];
                else if (use_par && k == 9)  exp_bit = (^d) ^ pt;
                else                         exp_bit = 1'b1;
                check($sformatf("%s_bit%0d_c%0d", tag, k, pos), 32'(TX_OUT), 32'(exp_bit));
            end
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, "_len"}, 32'(cyc), 32'(nbits * p));
        check({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
    endtask

    // Requests one frame, then scrambles every input to show they were latched
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] ps);
        int p;
        p          = (ps == 6'd0) ? 1 : int'(ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        Prescale   = 6'd3;
        capture(tag, d, pe, pt, p);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("idle_tx_%0d", i), 32'(TX_OUT), 32'd1);
            check($sformatf("idle_busy_%0d", i), 32'(Busy), 32'd0);
        end

        run_frame("np_a5", 8'hA5, 1'b0, 1'b0, 6'd8);

        run_frame("par_a5_even", 8'hA5, 1'b1, 1'b0, 6'd16);
        run_frame("par_a5_odd",  8'hA5, 1'b1, 1'b1, 6'd16);
        run_frame("par_01_even", 8'h01, 1'b1, 1'b0, 6'd16);
        run_frame("par_01_odd",  8'h01, 1'b1, 1'b1, 6'd16);

        // Back-to-back with Data_Valid held; data change after acceptance
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd4;
        Data_Valid = 1'b1;
        @(posedge clk); #1;
        P_DATA = 8'hFF;
        capture("b2b_0", 8'h3C, 1'b0, 1'b0, 4);
        check("b2b_gap_busy", 32'(Busy), 32'd0);
        @(posedge clk); #1;
        Data_Valid = 1'b0;
        capture("b2b_1", 8'hFF, 1'b0, 1'b0, 4);

        // Reset during data bit 3
        P_DATA     = 8'h5A;
        Prescale   = 6'd8;
        Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
        repeat (35) begin
            @(posedge clk); #1;
        end
        check("mid_bit3_tx", 32'(TX_OUT), 32'd1);
        check("mid_bit3_busy", 32'(Busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_tx", 32'(TX_OUT), 32'd1);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(Busy), 32'd0);
        run_frame("after_rst", 8'h5A, 1'b0, 1'b0, 6'd8);

        // Minimum prescale
        run_frame("pre0", 8'h80, 1'b0, 1'b0, 6'd0);
        run_frame("pre1", 8'h80, 1'b0, 1'b0, 6'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
